// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the MIPS control path and mul_div_unit.
// Clock and reset stay as plain ports on the unit itself.
interface mul_div_unit_if #(
   parameter int DATA_W = 32
);
   logic              i_start;
   logic [1:0]        i_op;
   logic [DATA_W-1:0] i_a;
   logic [DATA_W-1:0] i_b;
   logic              i_we_hi;
   logic              i_we_lo;
   logic [DATA_W-1:0] i_wd;
   logic [DATA_W-1:0] o_hi;
   logic [DATA_W-1:0] o_lo;
   logic              o_busy;
   logic              o_done;
   logic              o_div_by_zero;

   modport master (
      output i_start, i_op, i_a, i_b, i_we_hi, i_we_lo, i_wd,
      input  o_hi, o_lo, o_busy, o_done, o_div_by_zero
   );

   modport slave (
      input  i_start, i_op, i_a, i_b, i_we_hi, i_we_lo, i_wd,
      output o_hi, o_lo, o_busy, o_done, o_div_by_zero
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add / restoring shift-subtract steps then a sign-fix cycle.
// Optional MDU_FAST_MULT_EN: MULT/MULTU use a single-cycle product and skip the iteration phase.
module mul_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   mul_div_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic                sign_a_q, sign_a_d;
   logic                sign_b_q, sign_b_d;
   logic [DATA_W-1:0]   a_raw_q, a_raw_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                dbz_q, dbz_d;
   logic                launch;

   // Operand conditioning at launch: op[0]=1 selects the unsigned variants.
   logic                in_sign_a, in_sign_b;
   logic [DATA_W-1:0]   in_abs_a, in_abs_b;

   assign in_sign_a = ~bus.i_op[0] & bus.i_a[DATA_W-1];
   assign in_sign_b = ~bus.i_op[0] & bus.i_b[DATA_W-1];
   assign in_abs_a  = in_sign_a ? -bus.i_a : bus.i_a;
   assign in_abs_b  = in_sign_b ? -bus.i_b : bus.i_b;

`ifdef MDU_FAST_MULT_EN
   logic [2*DATA_W-1:0] fast_prod;
   assign fast_prod = {{DATA_W{1'b0}}, in_abs_a} * {{DATA_W{1'b0}}, in_abs_b};
`endif

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_rem_sh;
   logic                div_ge;
   logic [DATA_W-1:0]   div_rem_nx;
   logic [2*DATA_W-1:0] mul_step, div_step;

   assign mul_sum    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign mul_step   = {mul_sum, acc_q[DATA_W-1:1]};
   assign div_rem_sh = acc_q[2*DATA_W-1:DATA_W-1];
   assign div_ge     = div_rem_sh >= {1'b0, b_q};
   assign div_rem_nx = div_ge ? (div_rem_sh[DATA_W-1:0] - b_q) : div_rem_sh[DATA_W-1:0];
   assign div_step   = {div_rem_nx, acc_q[DATA_W-2:0], div_ge};

   // Sign correction; signs are latched as zero for unsigned ops.
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
   assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
   assign rem_fix  = sign_a_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

   // NOTE: every next-state variable gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      a_raw_d  = a_raw_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dbz_d    = 1'b0;
      launch   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.i_we_hi) hi_d = bus.i_wd;
            if (bus.i_we_lo) lo_d = bus.i_wd;
            launch = bus.i_start;
         end
         S_CALC: begin
            acc_d = op_q[1] ? div_step : mul_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            if (!op_q[1]) begin
               hi_d = prod_fix[2*DATA_W-1:DATA_W];
               lo_d = prod_fix[DATA_W-1:0];
            end else if (b_q == '0) begin
               hi_d  = a_raw_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            // A start presented on the FIX edge chains straight into the next op.
            launch  = bus.i_start;
         end
         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         op_d     = bus.i_op;
         sign_a_d = in_sign_a;
         sign_b_d = in_sign_b;
         a_raw_d  = bus.i_a;
         b_d      = in_abs_b;
         acc_d    = {{DATA_W{1'b0}}, in_abs_a};
         cnt_d    = '0;
         busy_d   = 1'b1;
         state_d  = S_CALC;
`ifdef MDU_FAST_MULT_EN
         if (!bus.i_op[1]) begin
            acc_d   = fast_prod;
            state_d = S_FIX;
         end
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         a_raw_q  <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         a_raw_q  <= a_raw_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

   assign bus.o_hi          = hi_q;
   assign bus.o_lo          = lo_q;
   assign bus.o_busy        = busy_q;
   assign bus.o_done        = done_q;
   assign bus.o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, timing corner sequences and
// random ops against a plain-arithmetic HI/LO reference model.
module tb_mul_div_unit;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   mul_div_unit_if bus ();

   mul_div_unit dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [1:0] op);
`ifdef MDU_FAST_MULT_EN
      if (!op[1]) return 1;
`endif
      return 33;
   endfunction

   // Reference: architectural MIPS results from ordinary integer arithmetic.
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
      longint      p;
      logic [63:0] up;
      int          sa, sb;
      sa  = a;
      sb  = b;
      dbz = 1'b0;
      hi  = '0;
      lo  = '0;
      case (op)
         OP_MULT: begin
            p  = longint'(sa) * longint'(sb);
            hi = p[63:32];
            lo = p[31:0];
         end
         OP_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         OP_DIV: begin
            if (b == 32'd0) begin
               dbz = 1'b1; lo = 32'hFFFF_FFFF; hi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000; hi = 32'd0;
            end else begin
               lo = sa / sb;
               hi = sa % sb;
            end
         end
         default: begin
            if (b == 32'd0) begin
               dbz = 1'b1; lo = 32'hFFFF_FFFF; hi = a;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edbz);
      int n;
      bit gap;
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_op = op; bus.i_a = a; bus.i_b = b;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      n   = 0;
      gap = 1'b0;
      while (!bus.o_done && n < 40) begin
         if (!bus.o_busy) gap = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      check({name, " latency"}, n, exp_lat(op));
      check({name, " busy_gap"}, gap, 0);
      check({name, " hi"}, bus.o_hi, ehi);
      check({name, " lo"}, bus.o_lo, elo);
      check({name, " dbz"}, bus.o_div_by_zero, edbz);
      check({name, " busy_at_done"}, bus.o_busy, 0);
      @(posedge clk); #1;
      check({name, " done_pulse"}, {bus.o_done, bus.o_div_by_zero}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      bit          seen;
      logic [1:0]  op;
      logic [31:0] a, b, ehi, elo;
      logic        edbz;

      vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
      vecs[5]  = '{OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
      vecs[6]  = '{OP_MULT,  32'd6,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFE8, 1'b0};
      vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
      vecs[8]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
      vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
      vecs[10] = '{OP_MULTU, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         1'b0};
      vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};

      bus.i_start = 1'b0; bus.i_op = '0; bus.i_a = '0; bus.i_b = '0;
      bus.i_we_hi = 1'b0; bus.i_we_lo = 1'b0; bus.i_wd = '0;

      // Reset held, then released with no start.
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset hi", bus.o_hi, 0);
      check("reset lo", bus.o_lo, 0);
      check("reset flags", {bus.o_busy, bus.o_done, bus.o_div_by_zero}, 0);

      // Reset asserted at E15 of a DIVU aborts without writing HI/LO.
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_op = OP_DIVU; bus.i_a = 32'd100; bus.i_b = 32'd7;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      check("abort busy_started", bus.o_busy, 1);
      repeat (15) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("abort async busy", bus.o_busy, 0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.o_done || bus.o_busy) seen = 1'b1;
      end
      check("abort no_done", seen, 0);
      check("abort hi", bus.o_hi, 0);
      check("abort lo", bus.o_lo, 0);

      // Directed vectors.
      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].dbz);

      // MTHI / both / MTLO while idle.
      @(negedge clk); bus.i_we_hi = 1'b1; bus.i_wd = 32'hAAAA_5555;
      @(posedge clk); #1 bus.i_we_hi = 1'b0;
      check("mthi hi", bus.o_hi, 32'hAAAA_5555);
      @(negedge clk); bus.i_we_hi = 1'b1; bus.i_we_lo = 1'b1; bus.i_wd = 32'h0F0F_0F0F;
      @(posedge clk); #1 begin bus.i_we_hi = 1'b0; bus.i_we_lo = 1'b0; end
      check("mtboth hi", bus.o_hi, 32'h0F0F_0F0F);
      check("mtboth lo", bus.o_lo, 32'h0F0F_0F0F);
      @(negedge clk); bus.i_we_lo = 1'b1; bus.i_wd = 32'h1111_1111;
      @(posedge clk); #1 bus.i_we_lo = 1'b0;
      check("mtlo lo", bus.o_lo, 32'h1111_1111);
      check("mtlo hi_kept", bus.o_hi, 32'h0F0F_0F0F);

      // MTLO and start issued mid-CALC are dropped.
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_op = OP_DIVU; bus.i_a = 32'd100; bus.i_b = 32'd7;
      @(posedge clk); #1 bus.i_start = 1'b0;
      n = 0;
      repeat (10) begin @(posedge clk); n++; end
      @(negedge clk);
      bus.i_we_lo = 1'b1; bus.i_wd = 32'hDEAD_BEEF;
      bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_a = 32'd2; bus.i_b = 32'd2;
      @(posedge clk); #1;
      n++;
      bus.i_we_lo = 1'b0; bus.i_start = 1'b0;
      check("midcalc lo_unchanged", bus.o_lo, 32'h1111_1111);
      while (!bus.o_done && n < 60) begin @(posedge clk); #1; n++; end
      check("midcalc latency", n, 33);
      check("midcalc lo", bus.o_lo, 32'd14);
      check("midcalc hi", bus.o_hi, 32'd2);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.o_busy || bus.o_done) seen = 1'b1;
      end
      check("midcalc start_not_queued", seen, 0);

      // MTHI and start in the same idle cycle: MT lands, result overwrites at FIX.
      @(negedge clk);
      bus.i_we_hi = 1'b1; bus.i_wd = 32'hCAFE_F00D;
      bus.i_start = 1'b1; bus.i_op = OP_DIVU; bus.i_a = 32'd100; bus.i_b = 32'd7;
      @(posedge clk); #1 begin bus.i_we_hi = 1'b0; bus.i_start = 1'b0; end
      check("mt_start hi_written", bus.o_hi, 32'hCAFE_F00D);
      n = 0;
      while (!bus.o_done && n < 40) begin @(posedge clk); #1; n++; end
      check("mt_start latency", n, 33);
      check("mt_start hi", bus.o_hi, 32'd2);

      // Back-to-back: second start held on the E33 edge.
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_op = OP_DIVU; bus.i_a = 32'd100; bus.i_b = 32'd7;
      @(posedge clk); #1 bus.i_start = 1'b0;
      repeat (32) @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_a = 32'd3; bus.i_b = 32'd5;
      @(posedge clk); #1 bus.i_start = 1'b0;
      check("b2b first_done", bus.o_done, 1);
      check("b2b first_lo", bus.o_lo, 32'd14);
      check("b2b second_busy", bus.o_busy, 1);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.o_done && n < 40);
      check("b2b second_latency", n, exp_lat(OP_MULTU));
      check("b2b second_lo", bus.o_lo, 32'd15);
      check("b2b second_hi", bus.o_hi, 32'd0);

      // Random ops against the reference model.
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: a = $urandom_range(0, 1000);
            3: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         model(op, a, b, ehi, elo, edbz);
         run_op($sformatf("rnd%0d", i), op, a, b, ehi, elo, edbz);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
